junction_controller: RTL and testbench

//  Sequences two traffic-light heads (north-south, east-west) at one junction, with a

---
 rtl/junction_controller.sv | 128 ++++++++++++
 tb/tb_junction_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/junction_controller.sv
// Junction-level scheduler for two traffic-light heads (NS, EW) with a pedestrian all-red walk phase.
// Latency: lamps are a Moore decode of the registered state, so they change on the edge that changes the state.
// Backpressure: none; en=0 freezes state and timer, while pedestrian requests keep latching.
module junction_controller #(
    parameter int CNT_W        = 8,
    parameter int PREP_TICKS   = 2,
    parameter int GREEN_TICKS  = 8,
    parameter int AMBER_TICKS  = 3,
    parameter int ALLRED_TICKS = 2,
    parameter int WALK_TICKS   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       en,
    input  logic       ped_req,
    output logic       ns_red,
    output logic       ns_orange,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_orange,
    output logic       ew_green,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        ALLRED_A = 3'd0,
        NS_PREP  = 3'd1,
        NS_GO    = 3'd2,
        NS_STOP  = 3'd3,
        ALLRED_B = 3'd4,
        EW_PREP  = 3'd5,
        EW_GO    = 3'd6,
        EW_STOP  = 3'd7
    } state_t;

    // A zero-length phase would otherwise wrap the timer, so it runs for one tick.
    localparam int PREP_D   = (PREP_TICKS   < 1) ? 1 : PREP_TICKS;
    localparam int GREEN_D  = (GREEN_TICKS  < 1) ? 1 : GREEN_TICKS;
    localparam int AMBER_D  = (AMBER_TICKS  < 1) ? 1 : AMBER_TICKS;
    localparam int ALLRED_D = (ALLRED_TICKS < 1) ? 1 : ALLRED_TICKS;
    localparam int WALK_D   = (WALK_TICKS   < 1) ? 1 : WALK_TICKS;

    localparam logic [CNT_W-1:0] PREP_LD   = CNT_W'(PREP_D - 1);
    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_D - 1);
    localparam logic [CNT_W-1:0] AMBER_LD  = CNT_W'(AMBER_D - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_D - 1);
    localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_D - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic             ped_pend, ped_pend_nxt;
    logic             walk_q, walk_nxt;
    logic             ack_q, ack_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ALLRED_A;
            timer    <= ALLRED_LD;
            ped_pend <= 1'b0;
            walk_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            ped_pend <= ped_pend_nxt;
            walk_q   <= walk_nxt;
            ack_q    <= ack_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        ped_pend_nxt = ped_pend | ped_req;
        walk_nxt     = walk_q;
        ack_nxt      = 1'b0;
        if (en && tick) begin
            if (timer == '0) begin
                state_nxt = state_t'(state + 3'd1);
                walk_nxt  = 1'b0;
                case (state_nxt)
                    ALLRED_A, ALLRED_B: begin
                        // The request seen on the entry edge is consumed by this grant.
                        if (ped_pend || ped_req) begin
                            timer_nxt    = WALK_LD;
                            walk_nxt     = 1'b1;
                            ack_nxt      = 1'b1;
                            ped_pend_nxt = 1'b0;
                        end else begin
                            timer_nxt = ALLRED_LD;
                        end
                    end
                    NS_PREP, EW_PREP: timer_nxt = PREP_LD;
                    NS_GO, EW_GO:     timer_nxt = GREEN_LD;
                    default:          timer_nxt = AMBER_LD;
                endcase
            end else begin
                timer_nxt = timer - 1'b1;
            end
        end
    end

    always_comb begin
        ns_red    = 1'b0;
        ns_orange = 1'b0;
        ns_green  = 1'b0;
        ew_red    = 1'b0;
        ew_orange = 1'b0;
        ew_green  = 1'b0;
        case (state)
            NS_PREP: begin ns_red = 1'b1; ns_orange = 1'b1; ew_red = 1'b1; end
            NS_GO:   begin ns_green = 1'b1; ew_red = 1'b1; end
            NS_STOP: begin ns_orange = 1'b1; ew_red = 1'b1; end
            EW_PREP: begin ew_red = 1'b1; ew_orange = 1'b1; ns_red = 1'b1; end
            EW_GO:   begin ew_green = 1'b1; ns_red = 1'b1; end
            EW_STOP: begin ew_orange = 1'b1; ns_red = 1'b1; end
            default: begin ns_red = 1'b1; ew_red = 1'b1; end
        endcase
    end

    assign walk    = walk_q;
    assign ped_ack = ack_q;
    assign phase   = state;

endmodule

// File: tb/tb_junction_controller.sv
// Bench for junction_controller: directed scenarios plus random traffic against a phase/ticks-remaining model.
module tb_junction_controller;

    logic       clk = 1'b0;
    logic       reset, tick, en, ped_req;
    logic       ns_red, ns_orange, ns_green, ew_red, ew_orange, ew_green, walk, ped_ack;
    logic [2:0] phase;

    int checks   = 0;
    int failures = 0;

    // Phase durations in ticks, indexed by phase number.
    int dur [8] = '{2, 2, 8, 3, 2, 2, 8, 3};
    localparam int WALK = 5;

    int m_phase, m_rem;
    bit m_pend, m_walk, m_ack;
    int seq [$];

    junction_controller dut (
        .clk(clk), .reset(reset), .tick(tick), .en(en), .ped_req(ped_req),
        .ns_red(ns_red), .ns_orange(ns_orange), .ns_green(ns_green),
        .ew_red(ew_red), .ew_orange(ew_orange), .ew_green(ew_green),
        .walk(walk), .ped_ack(ped_ack), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase = 0; m_rem = dur[0]; m_pend = 0; m_walk = 0; m_ack = 0;
    endtask

    // One clock of the junction, in terms of "ticks left in this phase".
    task automatic model_step(input bit e, input bit t, input bit r);
        bit consumed = 0;
        m_ack = 0;
        if (e && t) begin
            m_rem--;
            if (m_rem == 0) begin
                m_phase = (m_phase + 1) % 8;
                m_walk  = 0;
                m_rem   = dur[m_phase];
                if ((m_phase == 0 || m_phase == 4) && (m_pend || r)) begin
                    m_walk = 1; m_ack = 1; m_pend = 0; consumed = 1;
                    m_rem  = WALK;
                end
            end
        end
        if (r && !consumed) m_pend = 1;
    endtask

    // Lamp triple {red, orange, green} for a head whose PREP phase number is base.
    function automatic logic [2:0] head(input int p, input int base);
        if (p == base)     return 3'b110;
        if (p == base + 1) return 3'b001;
        if (p == base + 2) return 3'b010;
        return 3'b100;
    endfunction

    task automatic check_outputs(input string tag);
        logic [6:0] got, exp;
        got = {ns_red, ns_orange, ns_green, ew_red, ew_orange, ew_green, walk};
        exp = {head(m_phase, 1), head(m_phase, 5), m_walk};
        checks++;
        assert (phase === 3'(m_phase)) else begin
            failures++; $error("FAIL %s phase got=%0d exp=%0d", tag, phase, m_phase);
        end
        checks++;
        assert (got === exp) else begin
            failures++; $error("FAIL %s lamps got=%b exp=%b", tag, got, exp);
        end
        checks++;
        assert (ped_ack === m_ack) else begin
            failures++; $error("FAIL %s ped_ack got=%b exp=%b", tag, ped_ack, m_ack);
        end
        checks++;
        assert ((ns_green & ew_green) === 1'b0) else begin
            failures++; $error("FAIL %s both_green got=1 exp=0", tag);
        end
        checks++;
        assert ((walk & (ns_green | ew_green)) === 1'b0) else begin
            failures++; $error("FAIL %s walk_with_green got=1 exp=0", tag);
        end
    endtask

    task automatic step(input bit e, input bit t, input bit r, input string tag);
        en = e; tick = t; ped_req = r;
        @(posedge clk);
        model_step(e, t, r);
        #1;
        check_outputs(tag);
    endtask

    task automatic run_until(input int p, input int budget);
        int n = 0;
        while (phase !== 3'(p) && n < budget) begin
            step(1, 1, 0, "run_until");
            n++;
        end
        checks++;
        assert (phase === 3'(p)) else begin
            failures++; $error("FAIL run_until phase got=%0d exp=%0d (budget expired)", phase, p);
        end
    endtask

    task automatic check_seq(input int k, input string tag);
        checks++;
        assert (phase === 3'(seq[k % 30])) else begin
            failures++; $error("FAIL %s seq[%0d] got=%0d exp=%0d", tag, k, phase, seq[k % 30]);
        end
    endtask

    initial begin
        int prev, dw, seen, walk_cnt, ack_cnt, a0_cnt, a0_walk, entries, green_left;

        for (int p = 0; p < 8; p++)
            for (int n = 0; n < dur[p]; n++) seq.push_back(p);

        // Reset state
        reset = 1'b1; en = 1'b0; tick = 1'b0; ped_req = 1'b0;
        #12;
        model_reset();
        check_outputs("reset");
        reset = 1'b0;
        check_seq(0, "t1");

        // Test 1: tick every clk, two full cycles
        for (int k = 1; k <= 60; k++) begin
            step(1, 1, 0, "t1");
            check_seq(k, "t1");
        end

        // Test 2: tick every 4th clk; each dwell is 4x its tick count
        prev = phase; dw = 0; seen = 0;
        for (int i = 0; i < 160; i++) begin
            step(1, (i % 4) == 3, 0, "t2");
            dw++;
            if (int'(phase) != prev) begin
                if (seen > 0) begin
                    checks++;
                    assert (dw == 4 * dur[prev]) else begin
                        failures++; $error("FAIL t2_dwell phase=%0d got=%0d exp=%0d", prev, dw, 4 * dur[prev]);
                    end
                end
                seen++; prev = phase; dw = 0;
            end
        end

        // Test 3: single ped pulse during NS_GO
        run_until(2, 100);
        step(1, 1, 1, "t3");
        walk_cnt = 0; ack_cnt = 0; a0_cnt = 0; a0_walk = 0;
        for (int i = 0; i < 35; i++) begin
            step(1, 1, 0, "t3");
            if (phase == 3'd4 && walk) walk_cnt++;
            if (phase == 3'd0) begin a0_cnt++; a0_walk += walk; end
            ack_cnt += ped_ack;
        end
        checks++;
        assert (walk_cnt == WALK) else begin failures++; $error("FAIL t3_walk_len got=%0d exp=%0d", walk_cnt, WALK); end
        checks++;
        assert (ack_cnt == 1) else begin failures++; $error("FAIL t3_ack_count got=%0d exp=1", ack_cnt); end
        checks++;
        assert (a0_cnt == 2 && a0_walk == 0) else begin
            failures++; $error("FAIL t3_next_allred len=%0d walk=%0d exp len=2 walk=0", a0_cnt, a0_walk);
        end

        // Test 4: ped_req held high
        prev = phase; entries = 0; ack_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            step(1, 1, 1, "t4");
            if (int'(phase) != prev && (phase == 3'd0 || phase == 3'd4)) entries++;
            ack_cnt += ped_ack;
            prev = phase;
        end
        checks++;
        assert (entries >= 2 && ack_cnt == entries) else begin
            failures++; $error("FAIL t4_ack_per_entry got=%0d exp=%0d", ack_cnt, entries);
        end

        // Test 5: freeze mid NS_GO
        run_until(2, 100);
        for (int i = 0; i < 3; i++) step(1, 1, 0, "t5");
        for (int i = 0; i < 10; i++) step(0, 1, 0, "t5_frozen");
        checks++;
        assert (phase === 3'd2 && ns_green === 1'b1) else begin
            failures++; $error("FAIL t5_frozen phase=%0d ns_green=%b exp 2/1", phase, ns_green);
        end
        green_left = 0;
        while (phase == 3'd2 && green_left < 20) begin
            step(1, 1, 0, "t5");
            green_left++;
        end
        checks++;
        assert (green_left == 5) else begin failures++; $error("FAIL t5_green_left got=%0d exp=5", green_left); end

        // Test 6: async reset mid EW_GO
        run_until(6, 100);
        for (int i = 0; i < 3; i++) step(1, 1, 1, "t6");
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs("t6_reset");
        #1 reset = 1'b0;
        check_seq(0, "t6");
        for (int k = 1; k <= 30; k++) begin
            step(1, 1, 0, "t6");
            check_seq(k, "t6");
        end

        // Random traffic
        for (int i = 0; i < 1500; i++)
            step(($urandom % 8) != 0, ($urandom % 3) == 0, ($urandom % 16) == 0, "rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
